// File: rtl/fetch_pkg.sv
// Shared fetch/decode definitions: FSM states, MIPS field positions and widths
// also used by decode and the sign extender.
package fetch_pkg;
   localparam int INSTR_W    = 32;
   localparam int IMM_W      = 16;
   localparam int OPCODE_MSB = 31;
   localparam int OPCODE_LSB = 26;
   localparam int RS_MSB     = 25;
   localparam int RS_LSB     = 21;
   localparam int RT_MSB     = 20;
   localparam int RT_LSB     = 16;
   localparam int RD_MSB     = 15;
   localparam int RD_LSB     = 11;
   localparam int SHAMT_MSB  = 10;
   localparam int SHAMT_LSB  = 6;
   localparam int FUNCT_MSB  = 5;
   localparam int FUNCT_LSB  = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_WAIT,
      ST_HOLD
   } fetch_state_t;
endpackage

// File: rtl/instr_field_split.sv
// Pure combinational slice of an instruction word into its MIPS fields.
module instr_field_split
   import fetch_pkg::*;
(
   input  logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic [4:0]         rs,
   output logic [4:0]         rt,
   output logic [4:0]         rd,
   output logic [4:0]         shamt,
   output logic [5:0]         funct,
   output logic [IMM_W-1:0]   imm16
);
   assign opcode = instr[OPCODE_MSB:OPCODE_LSB];
   assign rs     = instr[RS_MSB:RS_LSB];
   assign rt     = instr[RT_MSB:RT_LSB];
   assign rd     = instr[RD_MSB:RD_LSB];
   assign shamt  = instr[SHAMT_MSB:SHAMT_LSB];
   assign funct  = instr[FUNCT_MSB:FUNCT_LSB];
   assign imm16  = instr[IMM_W-1:0];
endmodule

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch: owns the PC, runs the req/gnt/rvalid
// handshake and holds the fetched word until the datapath advances.
module instr_fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst_n,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic               imem_gnt,
   input  logic               imem_rvalid,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               advance,
   input  logic               branch_taken,
   input  logic [31:0]        branch_target,
   output logic               instr_valid,
   output logic [INSTR_W-1:0] instr,
   output logic [5:0]         opcode,
   output logic [4:0]         rs,
   output logic [4:0]         rt,
   output logic [4:0]         rd,
   output logic [4:0]         shamt,
   output logic [5:0]         funct,
   output logic [IMM_W-1:0]   imm16,
   output logic [31:0]        pc,
   output logic [31:0]        pc_plus4
);
   fetch_state_t state;

   assign pc_plus4  = pc + 32'd4;
   assign imem_addr = pc;

   // imem_req and instr_valid are registered alongside the state so they
   // never glitch with the handshake inputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= ST_IDLE;
         pc          <= RESET_PC;
         instr       <= '0;
         instr_valid <= 1'b0;
         imem_req    <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               state    <= ST_REQ;
               imem_req <= 1'b1;
            end
            ST_REQ: begin
               if (imem_gnt) begin
                  imem_req <= 1'b0;
                  if (imem_rvalid) begin
                     instr       <= imem_rdata;
                     instr_valid <= 1'b1;
                     state       <= ST_HOLD;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               if (imem_rvalid) begin
                  instr       <= imem_rdata;
                  instr_valid <= 1'b1;
                  state       <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (advance) begin
                  // Low target bits are dropped silently; no misalignment fault.
                  pc          <= branch_taken ? {branch_target[31:2], 2'b00} : pc_plus4;
                  instr_valid <= 1'b0;
                  imem_req    <= 1'b1;
                  state       <= ST_REQ;
               end
            end
            default: begin
               state    <= ST_IDLE;
               imem_req <= 1'b0;
            end
         endcase
      end
   end

   instr_field_split u_split (
      .instr  (instr),
      .opcode (opcode),
      .rs     (rs),
      .rt     (rt),
      .rd     (rd),
      .shamt  (shamt),
      .funct  (funct),
      .imm16  (imm16)
   );
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: vector table, corner sequences
// and randomized fetch/advance traffic against a transaction-level model.
module tb_instr_fetch_unit;
   localparam logic [31:0] RPC = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic        advance = 1'b0;
   logic        branch_taken = 1'b0;
   logic [31:0] branch_target = '0;
   logic        instr_valid;
   logic [31:0] instr;
   logic [5:0]  opcode, funct;
   logic [4:0]  rs, rt, rd, shamt;
   logic [15:0] imm16;
   logic [31:0] pc, pc_plus4;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   instr_fetch_unit #(.RESET_PC(RPC)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .advance(advance), .branch_taken(branch_taken), .branch_target(branch_target),
      .instr_valid(instr_valid), .instr(instr),
      .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
      .imm16(imm16), .pc(pc), .pc_plus4(pc_plus4)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Inputs change on negedge; outputs are sampled on negedge before driving.
   task automatic fetch(input int gdly, input int lat, input logic [31:0] data,
                        input logic [31:0] exp_pc);
      chk("req_at_fetch", imem_req, 1'b1);
      chk("addr_at_fetch", imem_addr, exp_pc);
      chk("valid_low_in_req", instr_valid, 1'b0);
      for (int i = 0; i < gdly; i++) begin
         imem_gnt = 1'b0;
         @(negedge clk);
         chk("req_stall", imem_req, 1'b1);
         chk("addr_stall", imem_addr, exp_pc);
      end
      imem_gnt = 1'b1;
      if (lat == 0) begin
         imem_rvalid = 1'b1;
         imem_rdata  = data;
      end
      @(negedge clk);
      imem_gnt = 1'b0;
      imem_rvalid = 1'b0;
      if (lat > 0) begin
         for (int i = 0; i < lat - 1; i++) begin
            imem_rdata = ~data;
            @(negedge clk);
            chk("req_low_wait", imem_req, 1'b0);
            chk("valid_low_wait", instr_valid, 1'b0);
         end
         imem_rvalid = 1'b1;
         imem_rdata  = data;
         @(negedge clk);
         imem_rvalid = 1'b0;
      end
      chk("valid_after_fetch", instr_valid, 1'b1);
      chk("instr", instr, data);
      chk("pc_in_hold", pc, exp_pc);
      chk("pc_plus4", pc_plus4, exp_pc + 32'd4);
      chk("req_low_hold", imem_req, 1'b0);
   endtask

   task automatic do_advance(input logic br, input logic [31:0] tgt,
                             input logic [31:0] exp_next);
      advance = 1'b1;
      branch_taken = br;
      branch_target = tgt;
      @(negedge clk);
      advance = 1'b0;
      branch_taken = 1'b0;
      branch_target = $urandom;
      chk("valid_drop", instr_valid, 1'b0);
      chk("pc_next", pc, exp_next);
      chk("req_after_adv", imem_req, 1'b1);
      chk("addr_after_adv", imem_addr, exp_next);
   endtask

   typedef struct {
      logic [31:0] data;
      logic        br;
      logic [31:0] tgt;
      logic [31:0] pc_exp;
      logic [31:0] next_exp;
      logic [5:0]  op;
      logic [4:0]  rs, rt, rd, sh;
      logic [5:0]  fn;
      logic [15:0] imm;
   } vec_t;

   vec_t vecs[5];

   initial begin
      logic [31:0] pc_m, data, tgt, held;
      logic        br;
      int          gd, lt;

      vecs[0] = '{32'h2008_FFFE, 1'b0, 32'h0,         32'h1000, 32'h1004,     6'h08, 5'd0, 5'd8,  5'd31, 5'd31, 6'h3E, 16'hFFFE};
      vecs[1] = '{32'h8C62_0004, 1'b1, 32'h0000_2003, 32'h1004, 32'h2000,     6'h23, 5'd3, 5'd2,  5'd0,  5'd0,  6'h04, 16'h0004};
      vecs[2] = '{32'h012A_4020, 1'b0, 32'h0,         32'h2000, 32'h2004,     6'h00, 5'd9, 5'd10, 5'd8,  5'd0,  6'h20, 16'h4020};
      vecs[3] = '{32'h0003_1080, 1'b0, 32'h0,         32'h2004, 32'h2008,     6'h00, 5'd0, 5'd3,  5'd2,  5'd2,  6'h00, 16'h1080};
      vecs[4] = '{32'h0800_0000, 1'b1, 32'hFFFF_FFFF, 32'h2008, 32'hFFFF_FFFC, 6'h02, 5'd0, 5'd0,  5'd0,  5'd0,  6'h00, 16'h0000};

      // Reset state and first request
      rst_n = 1'b0;
      #12;
      chk("rst_req", imem_req, 1'b0);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", pc, RPC);
      chk("rst_pc4", pc_plus4, RPC + 32'd4);
      chk("rst_fields", {opcode, rs, rt, rd, shamt, funct}, 32'h0);
      chk("rst_imm", imm16, 16'h0);
      @(negedge clk);
      rst_n = 1'b1;
      chk("idle_req_low", imem_req, 1'b0);
      @(negedge clk);
      chk("first_req", imem_req, 1'b1);
      chk("first_addr", imem_addr, RPC);
      chk("first_valid", instr_valid, 1'b0);
      chk("first_instr", instr, 32'h0);

      // Vector table: zero-wait fetch, field split, advance/branch
      for (int i = 0; i < 5; i++) begin
         fetch(0, 1, vecs[i].data, vecs[i].pc_exp);
         chk("opcode", opcode, vecs[i].op);
         chk("rs", rs, vecs[i].rs);
         chk("rt", rt, vecs[i].rt);
         chk("rd", rd, vecs[i].rd);
         chk("shamt", shamt, vecs[i].sh);
         chk("funct", funct, vecs[i].fn);
         chk("imm16", imm16, vecs[i].imm);
         do_advance(vecs[i].br, vecs[i].tgt, vecs[i].next_exp);
      end

      // Stalled grant at top of address space, then wrap
      fetch(5, 2, 32'hDEAD_BEEF, 32'hFFFF_FFFC);
      do_advance(1'b0, 32'h1234_5678, 32'h0);

      // Spurious advance while requesting, spurious rvalid while holding
      advance = 1'b1;
      branch_taken = 1'b1;
      branch_target = 32'h0000_8000;
      @(negedge clk);
      advance = 1'b0;
      branch_taken = 1'b0;
      chk("spur_adv_pc", pc, 32'h0);
      chk("spur_adv_req", imem_req, 1'b1);
      fetch(0, 0, 32'hCAFE_0001, 32'h0);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h5555_AAAA;
      @(negedge clk);
      imem_rvalid = 1'b0;
      chk("spur_rv_instr", instr, 32'hCAFE_0001);
      chk("spur_rv_valid", instr_valid, 1'b1);
      chk("spur_rv_pc", pc, 32'h0);
      chk("spur_rv_req", imem_req, 1'b0);
      do_advance(1'b0, 32'h0, 32'h4);

      // Reset while waiting for rvalid; late rvalid must be discarded
      imem_gnt = 1'b1;
      @(negedge clk);
      imem_gnt = 1'b0;
      chk("in_wait_req", imem_req, 1'b0);
      rst_n = 1'b0;
      #1;
      chk("async_rst_pc", pc, RPC);
      chk("async_rst_instr", instr, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h7777_7777;
      @(negedge clk);
      chk("late_rv_req", imem_req, 1'b1);
      imem_rvalid = 1'b1;
      @(negedge clk);
      imem_rvalid = 1'b0;
      chk("late_rv_valid", instr_valid, 1'b0);
      chk("late_rv_instr", instr, 32'h0);
      chk("restart_addr", imem_addr, RPC);

      // Randomized traffic against a transaction-level PC model
      pc_m = RPC;
      for (int n = 0; n < 60; n++) begin
         gd   = $urandom_range(0, 3);
         lt   = $urandom_range(0, 3);
         data = $urandom;
         fetch(gd, lt, data, pc_m);
         chk("rnd_opcode", opcode, data >> 26);
         chk("rnd_imm", imm16, data & 32'hFFFF);
         held = data;
         for (int h = $urandom_range(0, 2); h > 0; h--) begin
            imem_rvalid = $urandom_range(0, 1);
            imem_rdata  = $urandom;
            @(negedge clk);
            imem_rvalid = 1'b0;
            chk("rnd_hold_instr", instr, held);
         end
         br  = $urandom_range(0, 1);
         tgt = $urandom;
         if (n % 15 == 7) begin
            br  = 1'b1;
            tgt = 32'hFFFF_FFFD;
         end
         pc_m = br ? (tgt & 32'hFFFF_FFFC) : pc_m + 32'd4;
         do_advance(br, tgt, pc_m);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end
endmodule
